bg_index_fetch: RTL and testbench
=================================

// Module: bg_index_fetch
// PURPOSE
// - Upstream feeder of the level-background palette lookup.
//   - Converts VGA draw coordinates into an address for a synchronous background-image ROM.
//   - Takes the ROM's palette index and presents it, pipeline-aligned with delayed blank/sync, to the palette stage.
// - Supports a horizontal scroll offset, applied only at frame boundaries so the picture never tears.
// PARAMETERS
// - IMG_W       160  background image width in source pixels
// - IMG_H       120  background image height in source pixels
// - SCALE_SHIFT 2    screen-to-image downscale (log2); 640x480 -> 160x120
// - IDX_W       3    palette index width (8-entry palette)
// - ADDR_W      15   ROM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
// PORTS
// - clk          in   1       pixel clock (25 MHz VGA clock)
// - reset_n      in   1       asynchronous active-low reset
// - drawX        in   10      current pixel column, 0..639
// - drawY        in   10      current pixel row, 0..479
// - blank_in     in   1       1 = active video, 0 = blanking
// - hs_in        in   1       horizontal sync, active-low
// - vs_in        in   1       vertical sync, active-low
// - scroll_req   in   8       requested horizontal scroll, in image pixels
// - scroll_load  in   1       1-cycle strobe; captures scroll_req as pending
// - rom_addr     out  ADDR_W  address to the background ROM (1-cycle registered read)
// - rom_data     in   IDX_W   ROM palette index, valid 1 cycle after rom_addr
// - pal_index    out  IDX_W   index to the palette stage
// - blank_out    out  1       blank_in delayed to align with pal_index
// - hs_out       out  1       hs_in delayed to align with pal_index
// - vs_out       out  1       vs_in delayed to align with pal_index
// - frame_start  out  1       1-cycle pulse when the pending scroll is committed
// BEHAVIOUR
// - Reset (asynchronous, active-low):
//   - rom_addr=0, pal_index=0, blank_out=0, frame_start=0.
//   - hs_out=1, vs_out=1.
//   - scroll_pend=0, scroll_act=0, vs_q=1.
//   - All pipeline stages are cleared.
// - Pipeline, total latency 3 clk from drawX/drawY/blank/hs/vs sampling to pal_index and *_out:
//   - S1: col = ((drawX>>SCALE_SHIFT) + scroll_act) mod IMG_W; row = drawY>>SCALE_SHIFT; rom_addr <= row*IMG_W + col.
//   - S2: the ROM returns rom_data; the controls advance one stage.
//   - S3: pal_index <= blank_d2 ? rom_data : 0, so index 0 (black) during blanking.
// - Scroll wrap:
//   - The sum is taken modulo IMG_W by a single conditional subtract. Since scroll_act < IMG_W, one subtract suffices.
//   - scroll_req >= IMG_W is reduced modulo IMG_W at capture time, using repeated-subtract-free compare logic. This is valid because 255 < 2*IMG_W.
// - Row clamp: row >= IMG_H (only if parameters are mismatched) clamps to IMG_H-1.
// - Scroll FSM, states IDLE and PENDING:
//   - IDLE: scroll_load=1 -> capture into scroll_pend, go to PENDING.
//   - PENDING: falling edge of vs_in (vs_q=1 and vs_in=0) -> scroll_act <= scroll_pend, frame_start=1 for one cycle, go to IDLE.
//   - PENDING: scroll_load=1 again -> overwrite scroll_pend (last write wins), stay in PENDING.
//   - Simultaneous scroll_load and vs edge in PENDING: commit the old pending value, capture the new one, stay in PENDING.
// - scroll_act never changes outside a vs falling edge.
// - The reset_n deassertion mid-frame resumes at the next sampled coordinates. Outputs become valid 3 cycles later, with no recovery frame.
// - The multiply by IMG_W is a constant product; no DSP or multicycle path is needed.
// STRUCTURE
// - Shared package bg_pkg:
//   - typedef pal_idx_t (logic [IDX_W-1:0]), SCREEN_W=640, SCREEN_H=480.
//   - typedef scroll_state_t enum {IDLE, PENDING}.
// - One sub-module: bg_ctrl_delay, a parameterised N-stage shift register for the blank/hs/vs bundle. Its reset value is a parameter: blank 0, syncs 1.
// - The address stage, the scroll FSM and the index register stay in this module.
// TESTING
// - Reset: hold reset_n=0 -> pal_index=0, hs_out=vs_out=1, blank_out=0, rom_addr=0. Release -> first valid output 3 clk later.
// - Addressing, scroll_act=0:
//   - drawX=4, drawY=8, blank=1 -> rom_addr=2*160+1=321 one clk later.
//   - ROM model returns 5 -> pal_index=5 at cycle +3.
// - Wrap: load scroll 100, commit via vs edge; drawX=400 (col 100) -> col 200-160=40, rom_addr=row*160+40.
// - Commit timing:
//   - scroll_load mid-frame with 20 -> rom_addr is unchanged until the vs falling edge.
//   - Then frame_start is a 1-clk pulse, and the next line uses offset 20.
// - Double load: loads of 10 then 30 before vs, plus a load of 50 coincident with the vs edge -> commits 30, 50 stays pending, FSM in PENDING.
// - Blanking/alignment: random drawX/Y with toggling blank/hs/vs -> *_out equal inputs delayed exactly 3; pal_index=0 whenever blank_out=0.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared definitions for the background index fetch path.
//   pal_idx_t      : palette index type (8-entry palette)
//   SCREEN_W/H     : VGA active area the draw coordinates range over
//   scroll_state_t : scroll commit FSM states
//   ctrl_t         : blank/hsync/vsync bundle carried alongside the pixel pipe
package bg_pkg;

  localparam int PAL_IDX_W = 3;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  typedef enum logic {
    IDLE,
    PENDING
  } scroll_state_t;

  typedef struct packed {
    logic blank;  // 1 = active video
    logic hs;     // active-low
    logic vs;     // active-low
  } ctrl_t;

  // Idle value of the control bundle: blanking, syncs deasserted.
  localparam ctrl_t CTRL_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/bg_ctrl_delay.sv
// N-stage shift register for the video control bundle.
//   clk, reset_n : pixel clock, async active-low reset
//   d            : control bundle entering the pipe
//   q            : d delayed by N clocks
// Every stage resets to RST_VAL so the outputs show a clean blank/idle-sync
// pattern until real samples have propagated through.
module bg_ctrl_delay #(
  parameter int unsigned      N       = 2,
  parameter int unsigned      W       = 3,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  // NOTE: each stage of this small array is reset explicitly; a plain data
  // memory would not need it, but these bits drive sync outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/bg_index_fetch.sv
// Background palette-index fetch.
// Turns VGA draw coordinates into a background ROM address (with a
// horizontally wrapping scroll offset), then returns the ROM's palette index
// aligned with blank/hs/vs delayed by the same 3 clocks.
//   clk, reset_n         : pixel clock, async active-low reset
//   drawX, drawY         : current screen pixel
//   blank_in/hs_in/vs_in : video controls (blank 1 = active, syncs active-low)
//   scroll_req/load      : scroll request and its capture strobe
//   rom_addr / rom_data  : synchronous ROM port (data valid 1 clk after addr)
//   pal_index            : palette index, 0 during blanking
//   blank/hs/vs_out      : controls aligned with pal_index
//   frame_start          : 1-clk pulse when a pending scroll is committed
module bg_index_fetch
  import bg_pkg::*;
#(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int IDX_W       = PAL_IDX_W,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              blank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [7:0]        scroll_req,
  input  logic              scroll_load,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  pal_index,
  output logic              blank_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              frame_start
);

  localparam logic [10:0]       IMG_W_X = 11'(IMG_W);
  localparam logic [8:0]        IMG_W_S = 9'(IMG_W);
  localparam logic [9:0]        IMG_H_Y = 10'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  scroll_state_t state;
  logic [7:0]    scroll_pend;
  logic [7:0]    scroll_act;
  logic [7:0]    scroll_mod;
  logic          vs_q;
  logic          vs_fall;

  logic [9:0]        col_src;
  logic [10:0]       col_sum;
  logic [10:0]       col;
  logic [9:0]        row_raw;
  logic [9:0]        row;
  logic [ADDR_W-1:0] addr_next;

  ctrl_t ctrl_in;
  ctrl_t ctrl_d2;

  // ---------------- S1: address generation ----------------
  // NOTE: combinational blocks assign every output first so no latch is
  // inferred on any path.
  always_comb begin
    col_src = drawX >> SCALE_SHIFT;
    col_sum = 11'(col_src) + 11'(scroll_act);
    // scroll_act < IMG_W, so one conditional subtract completes the modulo.
    col     = (col_sum >= IMG_W_X) ? (col_sum - IMG_W_X) : col_sum;
    row_raw = drawY >> SCALE_SHIFT;
    // Only reachable with mismatched parameters; keeps the address in-image.
    row     = (row_raw >= IMG_H_Y) ? (IMG_H_Y - 10'd1) : row_raw;
    // Constant multiplier: reduces to shifts and adds.
    addr_next = ADDR_W'(row) * IMG_W_A + ADDR_W'(col);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rom_addr <= '0;
    else          rom_addr <= addr_next;
  end

  // ---------------- S1..S2: control bundle delay ----------------
  assign ctrl_in = '{blank: blank_in, hs: hs_in, vs: vs_in};

  bg_ctrl_delay #(
    .N       (2),
    .W       ($bits(ctrl_t)),
    .RST_VAL (CTRL_IDLE)
  ) u_ctrl_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ctrl_in),
    .q       (ctrl_d2)
  );

  // ---------------- S3: index and aligned controls ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_index <= '0;
      blank_out <= 1'b0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
    end else begin
      pal_index <= ctrl_d2.blank ? rom_data : '0;
      blank_out <= ctrl_d2.blank;
      hs_out    <= ctrl_d2.hs;
      vs_out    <= ctrl_d2.vs;
    end
  end

  // ---------------- Scroll commit FSM ----------------
  // 255 < 2*IMG_W, so a single compare-and-subtract reduces any request.
  assign scroll_mod = ({1'b0, scroll_req} >= IMG_W_S)
                    ? 8'({1'b0, scroll_req} - IMG_W_S)
                    : scroll_req;

  assign vs_fall = vs_q & ~vs_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      scroll_pend <= '0;
      scroll_act  <= '0;
      vs_q        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vs_q        <= vs_in;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (scroll_load) begin
            scroll_pend <= scroll_mod;
            state       <= PENDING;
          end
        end
        PENDING: begin
          // On a coincident load the old pending value commits while the
          // new one is captured, and the FSM stays armed for it.
          if (vs_fall) begin
            scroll_act  <= scroll_pend;
            frame_start <= 1'b1;
            if (!scroll_load) state <= IDLE;
          end
          if (scroll_load) scroll_pend <= scroll_mod;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_index_fetch.sv
module tb_bg_index_fetch;
  import bg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  drawX, drawY;
  logic        blank_in, hs_in, vs_in;
  logic [7:0]  scroll_req;
  logic        scroll_load;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data;
  logic [2:0]  pal_index;
  logic        blank_out, hs_out, vs_out, frame_start;

  int n_vec = 0;
  int n_err = 0;
  int tb_scroll = 0;  // scroll offset the bench expects to be active

  bg_index_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .drawX       (drawX),
    .drawY       (drawY),
    .blank_in    (blank_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .scroll_req  (scroll_req),
    .scroll_load (scroll_load),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pal_index   (pal_index),
    .blank_out   (blank_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

  // ROM content: index = (addr mod 8) + 4, wrapping in 3 bits.
  function automatic logic [2:0] rom_fn(input logic [14:0] a);
    return a[2:0] + 3'd4;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Reference address: wrapping column, clamped row.
  function automatic logic [14:0] ref_addr(input int x, input int y, input int s);
    int c, r;
    c = ((x / 4) + s) % 160;
    r = y / 4;
    if (r > 119) r = 119;
    return 15'(r * 160 + c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic b);
    drawX    = 10'(x);
    drawY    = 10'(y);
    blank_in = b;
  endtask

  // Holds one pixel for 3 clocks; reports rom_addr after 1 and outputs after 3.
  task automatic run_pix(input int x, input int y, input logic b,
                         output logic [14:0] a_seen, output logic [2:0] p_seen,
                         output logic b_seen);
    drive(x, y, b);
    step();
    a_seen = rom_addr;
    step();
    step();
    p_seen = pal_index;
    b_seen = blank_out;
  endtask

  // One-cycle scroll_load pulse.
  task automatic load_scroll(input int v);
    scroll_req  = 8'(v);
    scroll_load = 1'b1;
    step();
    scroll_load = 1'b0;
  endtask

  // vs falling edge; returns frame_start right after the edge and one clock later.
  task automatic vs_pulse(output logic fs0, output logic fs1);
    vs_in = 1'b0;
    step();
    fs0 = frame_start;
    vs_in = 1'b1;
    step();
    fs1 = frame_start;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(4, 8, 1'b1);
    hs_in = 1'b0; vs_in = 1'b1;
    scroll_req = 8'd0; scroll_load = 1'b0;
    step(); step();
    n_vec++; if (rom_addr !== 15'd0) begin n_err++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    n_vec++; if (pal_index !== 3'd0) begin n_err++; $display("FAIL reset_pal got=%0d exp=0", pal_index); end
    n_vec++; if ({blank_out, hs_out, vs_out} !== 3'b011) begin n_err++; $display("FAIL reset_ctrl got=%b exp=011", {blank_out, hs_out, vs_out}); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    // Release mid-cycle, inputs already at drawX=4, drawY=8, blank=1, hs=0.
    reset_n = 1'b1;
    hs_in = 1'b1;
    step();
    n_vec++; if (rom_addr !== 15'd321) begin n_err++; $display("FAIL release_addr got=%0d exp=321", rom_addr); end
    step();
    n_vec++; if (blank_out !== 1'b0 || pal_index !== 3'd0) begin n_err++; $display("FAIL release_early got blank=%b pal=%0d exp blank=0 pal=0", blank_out, pal_index); end
    step();
    n_vec++; if (blank_out !== 1'b1 || pal_index !== 3'd5) begin n_err++; $display("FAIL release_first got blank=%b pal=%0d exp blank=1 pal=5", blank_out, pal_index); end
  endtask

  task automatic test_addressing();
    logic [14:0] a; logic [2:0] p; logic b;
    run_pix(639, 479, 1'b1, a, p, b);
    n_vec++; if (a !== 15'd19199) begin n_err++; $display("FAIL addr_corner got=%0d exp=19199", a); end
    n_vec++; if (p !== 3'd3) begin n_err++; $display("FAIL pal_corner got=%0d exp=3", p); end
    run_pix(0, 0, 1'b1, a, p, b);
    n_vec++; if (a !== 15'd0 || p !== 3'd4) begin n_err++; $display("FAIL origin got addr=%0d pal=%0d exp addr=0 pal=4", a, p); end
    run_pix(4, 8, 1'b0, a, p, b);
    n_vec++; if (a !== 15'd321 || p !== 3'd0 || b !== 1'b0) begin n_err++; $display("FAIL blanked got addr=%0d pal=%0d blank=%b exp 321/0/0", a, p, b); end
  endtask

  task automatic test_scroll_wrap();
    logic [14:0] a; logic [2:0] p; logic b; logic f0, f1;
    load_scroll(100);
    vs_pulse(f0, f1);
    n_vec++; if (f0 !== 1'b1 || f1 !== 1'b0) begin n_err++; $display("FAIL wrap_commit_pulse got=%b%b exp=10", f0, f1); end
    tb_scroll = 100;
    run_pix(400, 40, 1'b1, a, p, b);
    n_vec++; if (a !== 15'd1640 || p !== 3'd4) begin n_err++; $display("FAIL wrap_400 got addr=%0d pal=%0d exp 1640/4", a, p); end
    run_pix(240, 0, 1'b1, a, p, b);
    n_vec++; if (a !== 15'd0) begin n_err++; $display("FAIL wrap_exact got=%0d exp=0", a); end
    run_pix(236, 4, 1'b1, a, p, b);
    n_vec++; if (a !== 15'd319 || p !== 3'd3) begin n_err++; $display("FAIL wrap_edge got addr=%0d pal=%0d exp 319/3", a, p); end
  endtask

  task automatic test_commit_timing();
    logic f0, f1;
    load_scroll(20);
    drive(4, 8, 1'b1);
    step();
    n_vec++; if (rom_addr !== 15'd421) begin n_err++; $display("FAIL pend_addr0 got=%0d exp=421", rom_addr); end
    step(); step(); step();
    n_vec++; if (rom_addr !== 15'd421 || frame_start !== 1'b0) begin n_err++; $display("FAIL pend_hold got addr=%0d fs=%b exp 421/0", rom_addr, frame_start); end
    vs_in = 1'b0;
    step();
    f0 = frame_start;
    n_vec++; if (rom_addr !== 15'd421) begin n_err++; $display("FAIL commit_edge_addr got=%0d exp=421", rom_addr); end
    vs_in = 1'b1;
    step();
    f1 = frame_start;
    n_vec++; if (f0 !== 1'b1 || f1 !== 1'b0) begin n_err++; $display("FAIL commit_pulse got=%b%b exp=10", f0, f1); end
    n_vec++; if (rom_addr !== 15'd341) begin n_err++; $display("FAIL commit_new_addr got=%0d exp=341", rom_addr); end
    tb_scroll = 20;
  endtask

  task automatic test_double_load();
    logic f0, f1;
    drive(4, 8, 1'b1);
    load_scroll(10);
    load_scroll(30);
    scroll_req = 8'd50; scroll_load = 1'b1; vs_in = 1'b0;
    step();
    scroll_load = 1'b0; vs_in = 1'b1;
    n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL dbl_pulse got=%b exp=1", frame_start); end
    n_vec++; if (dut.state !== PENDING) begin n_err++; $display("FAIL dbl_state got=%0d exp=PENDING", dut.state); end
    step();
    n_vec++; if (rom_addr !== 15'd351) begin n_err++; $display("FAIL dbl_commit30 got=%0d exp=351", rom_addr); end
    vs_pulse(f0, f1);
    n_vec++; if (f0 !== 1'b1 || rom_addr !== 15'd371) begin n_err++; $display("FAIL dbl_commit50 got fs=%b addr=%0d exp 1/371", f0, rom_addr); end
    n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL dbl_idle got=%0d exp=IDLE", dut.state); end
    vs_pulse(f0, f1);
    n_vec++; if (f0 !== 1'b0 || rom_addr !== 15'd371) begin n_err++; $display("FAIL idle_vs got fs=%b addr=%0d exp 0/371", f0, rom_addr); end
    tb_scroll = 50;
  endtask

  task automatic test_req_reduce();
    logic f0, f1;
    drive(4, 8, 1'b1);
    load_scroll(200);
    vs_pulse(f0, f1);
    n_vec++; if (rom_addr !== 15'd361) begin n_err++; $display("FAIL req200 got=%0d exp=361", rom_addr); end
    load_scroll(160);
    vs_pulse(f0, f1);
    n_vec++; if (rom_addr !== 15'd321) begin n_err++; $display("FAIL req160 got=%0d exp=321", rom_addr); end
    tb_scroll = 0;
  endtask

  task automatic test_alignment();
    int vx[40], vy[40];
    logic vb[40], vh[40], vv[40];
    logic [14:0] ea;
    logic [2:0] ep;
    for (int i = 0; i < 40; i++) begin
      vx[i] = int'($urandom_range(0, 639));
      vy[i] = int'($urandom_range(0, 479));
      vb[i] = 1'($urandom_range(0, 1));
      vh[i] = 1'($urandom_range(0, 1));
      vv[i] = 1'($urandom_range(0, 1));
      drive(vx[i], vy[i], vb[i]);
      hs_in = vh[i];
      vs_in = vv[i];
      step();
      ea = ref_addr(vx[i], vy[i], tb_scroll);
      n_vec++; if (rom_addr !== ea) begin n_err++; $display("FAIL align_addr[%0d] got=%0d exp=%0d", i, rom_addr, ea); end
      if (i >= 2) begin
        ep = vb[i-2] ? rom_fn(ref_addr(vx[i-2], vy[i-2], tb_scroll)) : 3'd0;
        n_vec++; if ({blank_out, hs_out, vs_out} !== {vb[i-2], vh[i-2], vv[i-2]}) begin n_err++; $display("FAIL align_ctrl[%0d] got=%b exp=%b", i, {blank_out, hs_out, vs_out}, {vb[i-2], vh[i-2], vv[i-2]}); end
        n_vec++; if (pal_index !== ep) begin n_err++; $display("FAIL align_pal[%0d] got=%0d exp=%0d", i, pal_index, ep); end
      end
    end
    vs_in = 1'b1;
    hs_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addressing();
    test_scroll_wrap();
    test_commit_timing();
    test_double_load();
    test_req_reduce();
    test_alignment();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
